multicycle_core: RTL and testbench
==================================

Name: multicycle_core

Overview:
- Parametrised multi-cycle RV32I execution core: fetch, decode, execute, memory and writeback run as FSM states over one shared memory bus with a ready handshake.
- Contains its own register file, immediate generator, ALU and load/store alignment.
- Adds what the single-cycle datapath lacks: reset, wait-states, JALR, branches, aligned sub-word access and a halt on illegal or misaligned operations.
- Sits between the top level and a unified instruction/data memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NUM_REGS, 32, architectural registers. Legal values: 16 (RV32E) or 32. A register index >= NUM_REGS is illegal.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_req  output  1  bus request, held until accepted.
- mem_we  output  1  1 = store, 0 = read (fetch or load).
- mem_addr  output  32  word-aligned byte address; bits [1:0] are always 0.
- mem_wdata  output  32  store data, lane-replicated.
- mem_wstrb  output  4  byte enables for stores; 0 on reads.
- mem_rdata  input  32  read data, valid in the cycle mem_ready=1.
- mem_ready  input  1  accept/complete; sampled only while mem_req=1.
- pc  output  32  PC of the current instruction.
- retire  output  1  one-cycle pulse when an instruction completes.
- halted  output  1  sticky; set on an illegal or misaligned operation.

Behaviour:
- Reset (async, rst_n=0):
  - State becomes FETCH; pc=RESET_PC.
  - mem_req=0, mem_we=0, mem_wstrb=0, mem_wdata=0, mem_addr=0, retire=0, halted=0.
  - All registers cleared to 0.
  - Deasserting reset mid-transaction abandons the transaction. The first cycle after reset starts a fresh fetch.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- FETCH:
  - mem_req=1, mem_addr=pc.
  - On mem_ready: latch mem_rdata into IR, go to DECODE. Otherwise stay.
- DECODE:
  - Read rs1/rs2 (x0 reads 0); form I/S/B/U/J immediates with sign extension.
  - Unsupported opcode/funct, or a register index >= NUM_REGS -> HALT.
- EXECUTE:
  - ALU ops: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. Shift amount is the low 5 bits.
  - LUI result = {imm[31:12],12'h0}.
  - JAL/JALR: result = pc+4; target = pc+immJ, or (rs1+immI) & ~1 for JALR.
  - A jump/branch target with target[1:0] != 0 -> HALT.
  - LOAD/STORE go to MEM; everything else goes to WRITEBACK.
- MEM:
  - Address = rs1+imm. LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; otherwise -> HALT with no bus request issued.
  - mem_addr = {addr[31:2],2'b00}.
  - Store: SB strobe = 4'b0001 << addr[1:0], data = rs2[7:0] replicated ×4. SH strobe = 4'b0011 << addr[1:0], data = rs2[15:0] replicated ×2. SW strobe = 4'hF.
  - Load: select the lane, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
  - Hold the request until mem_ready, then go to WRITEBACK.
- WRITEBACK:
  - Write rd unless rd=0 or the instruction is STORE/BRANCH.
  - pc = taken target or pc+4.
  - retire=1 for exactly this cycle; next state FETCH.
- Latency with zero-wait memory: ALU/LUI/JAL/branch = 4 cycles; load/store = 5 cycles. Each wait-state adds 1 cycle.
- HALT: absorbing until reset. halted=1, mem_req=0, no further retire; pc holds the faulting instruction's PC.
- The IR and all bus outputs stay stable while mem_req=1 and mem_ready=0.

Optional Feature:
- Macro: MULTICYCLE_CORE_BRANCH_EN.
- Defined: BEQ/BNE/BLT/BGE/BLTU/BGEU are supported. The comparison is done in EXECUTE; taken branch -> pc+immB, not taken -> pc+4. Branches retire in 4 cycles.
- Undefined: opcode 1100011 is illegal and goes to HALT in DECODE; no comparator logic is synthesised.

Test Plan:
- Reset release, zero-wait memory, program ADDI x1,x0,5; ADDI x2,x1,-7 -> retire every 4 cycles; x2=32'hFFFF_FFFE; pc=8 after the second retire.
- SW x2,0(x0); LB x3,1(x0); LBU x4,1(x0) with x2=32'h1234_80FF:
  - SW shows mem_wstrb=4'hF.
  - x3=32'hFFFF_FF80, x4=32'h0000_0080.
  - An SB to address 2 shows wstrb=4'b0100 and wdata with the byte replicated.
- mem_ready held low for 3 cycles on a fetch -> mem_addr/mem_req stable throughout; instruction retires in 7 cycles.
- LW x5,2(x0) -> halted=1, mem_req stays 0, pc = faulting PC, no retire thereafter; rst_n pulse low -> pc=RESET_PC, halted=0.
- JAL x1,+12 at pc=16 -> x1=20, next fetch address 28; JALR x0,0(x1) -> next fetch address 20.
- BRANCH_EN defined: BNE x1,x0,-8 with x1=1 at pc=40 -> next fetch 32. Macro undefined: same instruction -> halted=1.

Source files
------------

// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle RV32I core (fetch/decode/execute/mem/writeback) on one shared ready-handshake bus.
// Define MULTICYCLE_CORE_BRANCH_EN to add conditional branches; otherwise opcode 1100011 halts.
module multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                           OP_BR = 7'b1100011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                           OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, res_q, res_d, npc_q, npc_d;
    logic [31:0] rf_q [NUM_REGS];
    logic [31:0] rf_d [NUM_REGS];

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7b, is_st, is_mem, legal, bad_reg, misal;
    logic [31:0] rs1, rs2, imm_i, imm_s, imm_u, imm_j, alu_b, alu, addr, lane, ld, wdata;
    logic [3:0]  wstrb;

    assign opc    = ir_q[6:0];
    assign f3     = ir_q[14:12];
    assign f7b    = ir_q[30];
    assign is_st  = opc == OP_ST;
    assign is_mem = is_st || opc == OP_LD;
    assign rs1    = rf_q[ir_q[15 +: AW]];
    assign rs2    = rf_q[ir_q[20 +: AW]];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_u  = {ir_q[31:12], 12'h0};
    assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign alu_b  = opc == OP_REG ? rs2 : imm_i;

    assign addr  = rs1 + (is_st ? imm_s : imm_i);
    assign misal = f3[1:0] == 2'b01 ? addr[0] : f3[1:0] == 2'b10 ? |addr[1:0] : 1'b0;
    assign lane  = mem_rdata >> {addr[1:0], 3'b000};
    assign ld    = f3 == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
                   f3 == 3'b001 ? {{16{lane[15]}}, lane[15:0]} :
                   f3 == 3'b100 ? {24'h0, lane[7:0]} :
                   f3 == 3'b101 ? {16'h0, lane[15:0]} : lane;
    assign wstrb = f3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                   f3[1:0] == 2'b01 ? 4'b0011 << addr[1:0] : 4'hF;
    assign wdata = f3[1:0] == 2'b00 ? {4{rs2[7:0]}} : f3[1:0] == 2'b01 ? {2{rs2[15:0]}} : rs2;

`ifdef MULTICYCLE_CORE_BRANCH_EN
    logic [31:0] imm_b;
    logic        taken;
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign taken = f3 == 3'b000 ? rs1 == rs2 :
                   f3 == 3'b001 ? rs1 != rs2 :
                   f3 == 3'b100 ? $signed(rs1) < $signed(rs2) :
                   f3 == 3'b101 ? $signed(rs1) >= $signed(rs2) :
                   f3 == 3'b110 ? rs1 < rs2 : rs1 >= rs2;
`endif

    always_comb begin
        legal = 1'b0;
        case (opc)
            OP_LUI, OP_JAL: legal = 1'b1;
            OP_JALR: legal = f3 == 3'b000;
            OP_LD:   legal = f3 != 3'b011 && f3[2:1] != 2'b11;
            OP_ST:   legal = !f3[2] && f3[1:0] != 2'b11;
            OP_IMM:  legal = f3 == 3'b001 ? ir_q[31:25] == 7'b0 :
                             f3 == 3'b101 ? (ir_q[31:25] & 7'b1011111) == 7'b0 : 1'b1;
            OP_REG:  legal = (ir_q[31:25] & 7'b1011111) == 7'b0 && (!f7b || f3 == 3'b000 || f3 == 3'b101);
`ifdef MULTICYCLE_CORE_BRANCH_EN
            OP_BR:   legal = f3[2:1] != 2'b01;
`endif
            default: legal = 1'b0;
        endcase
    end

    // Only fields the instruction actually uses are range-checked; the rest hold immediate bits.
    assign bad_reg = (!(opc == OP_LUI || opc == OP_JAL) && {1'b0, ir_q[19:15]} >= 6'(NUM_REGS)) ||
                     ((opc == OP_REG || opc == OP_ST || opc == OP_BR) && {1'b0, ir_q[24:20]} >= 6'(NUM_REGS)) ||
                     (!(opc == OP_ST || opc == OP_BR) && {1'b0, ir_q[11:7]} >= 6'(NUM_REGS));

    always_comb begin
        case (f3)
            3'b000:  alu = opc == OP_REG && f7b ? rs1 - alu_b : rs1 + alu_b;
            3'b001:  alu = rs1 << alu_b[4:0];
            3'b010:  alu = {31'b0, $signed(rs1) < $signed(alu_b)};
            3'b011:  alu = {31'b0, rs1 < alu_b};
            3'b100:  alu = rs1 ^ alu_b;
            3'b101:  alu = f7b ? 32'($signed(rs1) >>> alu_b[4:0]) : rs1 >> alu_b[4:0];
            3'b110:  alu = rs1 | alu_b;
            default: alu = rs1 & alu_b;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        res_d     = res_q;
        npc_d     = npc_q;
        rf_d      = rf_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        retire    = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = legal && !bad_reg ? EXECUTE : HALT;
            EXECUTE: begin
                res_d = opc == OP_LUI ? imm_u : (opc == OP_JAL || opc == OP_JALR) ? pc_q + 32'd4 : alu;
                npc_d = opc == OP_JAL ? pc_q + imm_j : opc == OP_JALR ? (rs1 + imm_i) & ~32'd1 : pc_q + 32'd4;
`ifdef MULTICYCLE_CORE_BRANCH_EN
                if (opc == OP_BR && taken) npc_d = pc_q + imm_b;
`endif
                // Misaligned accesses halt here so MEM never raises a request for them.
                state_d = |npc_d[1:0] || (is_mem && misal) ? HALT : is_mem ? MEM : WRITEBACK;
            end
            MEM: begin
                mem_req   = 1'b1;
                mem_we    = is_st;
                mem_addr  = {addr[31:2], 2'b00};
                mem_wdata = is_st ? wdata : 32'h0;
                mem_wstrb = is_st ? wstrb : 4'h0;
                if (mem_ready) begin
                    res_d   = ld;
                    state_d = WRITEBACK;
                end
            end
            WRITEBACK: begin
                retire  = 1'b1;
                pc_d    = npc_q;
                if (ir_q[11:7] != 5'd0 && !is_st && opc != OP_BR) rf_d[ir_q[7 +: AW]] = res_q;
                state_d = FETCH;
            end
            default: state_d = HALT;
        endcase
        // The bus stays quiet while reset is held, even though the state already reads FETCH.
        if (!rst_n) begin
            mem_req  = 1'b0;
            mem_addr = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0;
            res_q   <= 32'h0;
            npc_q   <= 32'h0;
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            res_q   <= res_d;
            npc_q   <= npc_d;
            rf_q    <= rf_d;
        end
    end

    assign pc     = pc_q;
    assign halted = state_q == HALT;
endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: scoreboard bench; expected bus transactions and retires are queued, a monitor pops and compares.
module tb_multicycle_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic [3:0]  mem_wstrb;

    logic [31:0] mem [256];
    int          wait_n = 0;
    int          wcnt = 0;
    int          cyc = 1;
    int          n_chk = 0;
    int          n_pass = 0;

    typedef struct packed {logic we; logic [31:0] addr; logic [3:0] strb; logic [31:0] data;} txn_t;
    typedef struct packed {logic [31:0] pc; int gap;} ret_t;
    txn_t exp_txn[$];
    ret_t exp_ret[$];

    multicycle_core dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .retire(retire), .halted(halted)
    );

    initial forever #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_ready = mem_req && wcnt >= wait_n;

    always @(posedge clk) begin
        wcnt <= (!rst_n || !mem_req || mem_ready) ? 0 : wcnt + 1;
        cyc  <= rst_n ? cyc + 1 : 1;
    end

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fetch(input logic [31:0] a);
        exp_txn.push_back('{1'b0, a, 4'h0, 32'h0});
    endtask
    task automatic rd(input logic [31:0] a);
        exp_txn.push_back('{1'b0, a, 4'h0, 32'h0});
    endtask
    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        exp_txn.push_back('{1'b1, a, s, d});
    endtask
    task automatic ret(input logic [31:0] p, input int g);
        exp_ret.push_back('{p, g});
    endtask

    task automatic begin_test(input int wn);
        @(posedge clk);
        #1 rst_n = 1'b0;
        wait_n = wn;
        #1 chk(!mem_req && !mem_we && mem_addr == 0 && mem_wstrb == 0 && mem_wdata == 0 && !retire && !halted,
               "reset_outputs", {mem_req, mem_we, retire, halted}, 32'h0);
        chk(pc == 32'h0, "reset_pc", pc, 32'h0);
        exp_txn.delete();
        exp_ret.delete();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic go;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic end_test(input string name, input logic [31:0] halt_pc);
        int  n;
        bit  saw;
        n = 0;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(halted, {name, "_halt"}, {31'b0, halted}, 32'h1);
        chk(pc == halt_pc, {name, "_halt_pc"}, pc, halt_pc);
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            saw |= mem_req | retire | !halted;
        end
        chk(!saw, {name, "_quiet"}, {31'b0, saw}, 32'h0);
        chk(exp_txn.size() == 0 && exp_ret.size() == 0, {name, "_drained"},
            32'(exp_txn.size() + exp_ret.size()), 32'h0);
    endtask

    task automatic monitor;
        int          last_ret;
        bit          prev_wait;
        logic [31:0] p_addr, p_wdata;
        logic [3:0]  p_strb;
        logic        p_we;
        txn_t        e;
        ret_t        r;
        last_ret  = 0;
        prev_wait = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_ret  = 0;
                prev_wait = 1'b0;
            end else begin
                if (prev_wait)
                    chk(mem_req && mem_addr == p_addr && mem_we == p_we && mem_wstrb == p_strb && mem_wdata == p_wdata,
                        "bus_stable", mem_addr, p_addr);
                prev_wait = mem_req && !mem_ready;
                p_addr = mem_addr; p_we = mem_we; p_strb = mem_wstrb; p_wdata = mem_wdata;
                if (mem_req && mem_ready) begin
                    n_chk++;
                    if (exp_txn.size() == 0) begin
                        $display("FAIL txn_unexpected: got we=%0b addr=%h, expected no transaction", mem_we, mem_addr);
                    end else begin
                        e = exp_txn.pop_front();
                        if (mem_we == e.we && mem_addr == e.addr && mem_wstrb == e.strb && (!e.we || mem_wdata == e.data))
                            n_pass++;
                        else
                            $display("FAIL txn: got we=%0b addr=%h strb=%h wdata=%h, expected we=%0b addr=%h strb=%h wdata=%h",
                                     mem_we, mem_addr, mem_wstrb, mem_wdata, e.we, e.addr, e.strb, e.data);
                    end
                    if (mem_we)
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                end
                if (retire) begin
                    n_chk++;
                    if (exp_ret.size() == 0) begin
                        $display("FAIL retire_unexpected: got pc=%h, expected no retire", pc);
                    end else begin
                        r = exp_ret.pop_front();
                        if (pc == r.pc && cyc - last_ret == r.gap) n_pass++;
                        else $display("FAIL retire: got pc=%h gap=%0d, expected pc=%h gap=%0d", pc, cyc - last_ret, r.pc, r.gap);
                    end
                    last_ret = cyc;
                end
            end
        end
    endtask

    initial begin
        fork
            monitor;
        join_none

        // ADDI chain, then store the result to observe it.
        begin_test(0);
        mem[0] = addi(1, 0, 5);
        mem[1] = addi(2, 1, -7);
        mem[2] = enc_s(32'h100, 2, 0, 3'b010);
        fetch(0); fetch(4); fetch(8); wr(32'h100, 4'hF, 32'hFFFF_FFFE); fetch(12);
        ret(0, 4); ret(4, 4); ret(8, 5);
        go;
        end_test("addi", 32'd12);

        // Sub-word stores and loads against x2 = 0x1234_80FF.
        begin_test(0);
        mem[0]  = {20'h12348, 5'd2, 7'b0110111};
        mem[1]  = addi(2, 2, 32'hFF);
        mem[2]  = enc_s(0, 2, 0, 3'b010);
        mem[3]  = enc_i(1, 0, 3'b000, 3, 7'b0000011);
        mem[4]  = enc_i(1, 0, 3'b100, 4, 7'b0000011);
        mem[5]  = enc_s(32'h100, 3, 0, 3'b010);
        mem[6]  = enc_s(32'h104, 4, 0, 3'b010);
        mem[7]  = enc_s(2, 2, 0, 3'b000);
        mem[8]  = enc_s(2, 2, 0, 3'b001);
        mem[9]  = enc_i(2, 0, 3'b001, 5, 7'b0000011);
        mem[10] = enc_s(32'h108, 5, 0, 3'b010);
        fetch(0); fetch(4); fetch(8); wr(0, 4'hF, 32'h1234_80FF);
        fetch(12); rd(0); fetch(16); rd(0);
        fetch(20); wr(32'h100, 4'hF, 32'hFFFF_FF80);
        fetch(24); wr(32'h104, 4'hF, 32'h0000_0080);
        fetch(28); wr(0, 4'b0100, 32'hFFFF_FFFF);
        fetch(32); wr(0, 4'b1100, 32'h80FF_80FF);
        fetch(36); rd(0); fetch(40); wr(32'h108, 4'hF, 32'hFFFF_80FF); fetch(44);
        ret(0, 4); ret(4, 4);
        for (int a = 8; a <= 40; a += 4) ret(a, 5);
        go;
        end_test("subword", 32'd44);

        // Three wait-states on every transfer; x3 must read back zero after reset.
        begin_test(3);
        mem[0] = addi(1, 0, 7);
        mem[1] = enc_s(32'h100, 1, 0, 3'b010);
        mem[2] = enc_s(32'h104, 3, 0, 3'b010);
        fetch(0); fetch(4); wr(32'h100, 4'hF, 32'h7); fetch(8); wr(32'h104, 4'hF, 32'h0); fetch(12);
        ret(0, 7); ret(4, 11); ret(8, 11);
        go;
        end_test("waits", 32'd12);

        // Misaligned LW halts without a bus request.
        begin_test(0);
        mem[0] = addi(1, 0, 1);
        mem[1] = enc_i(2, 0, 3'b010, 5, 7'b0000011);
        fetch(0); fetch(4);
        ret(0, 4);
        go;
        end_test("misaligned", 32'd4);

        // JAL then JALR back through the link register.
        begin_test(0);
        for (int i = 0; i < 4; i++) mem[i] = addi(0, 0, 0);
        mem[4] = enc_j(12, 1);
        mem[7] = enc_i(0, 1, 3'b000, 0, 7'b1100111);
        mem[5] = enc_s(32'h100, 1, 0, 3'b010);
        fetch(0); fetch(4); fetch(8); fetch(12); fetch(16); fetch(28); fetch(20);
        wr(32'h100, 4'hF, 32'd20); fetch(24);
        ret(0, 4); ret(4, 4); ret(8, 4); ret(12, 4); ret(16, 4); ret(28, 4); ret(20, 5);
        go;
        end_test("jump", 32'd24);

        // BNE x1,x0,-8 at pc 40.
        begin_test(0);
        mem[0]  = addi(1, 0, 1);
        mem[1]  = enc_j(36, 0);
        mem[8]  = addi(1, 1, -1);
        mem[9]  = addi(0, 0, 0);
        mem[10] = enc_b(-8, 0, 1, 3'b001);
        fetch(0); fetch(4); fetch(40);
        ret(0, 4); ret(4, 4);
`ifdef MULTICYCLE_CORE_BRANCH_EN
        fetch(32); fetch(36); fetch(40); fetch(44);
        ret(40, 4); ret(32, 4); ret(36, 4); ret(40, 4);
        go;
        end_test("branch", 32'd44);
`else
        go;
        end_test("branch", 32'd40);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
